// File: rtl/regfile_param.sv
// Parametrised multi-port register file with optional hardwired zero register,
// write-to-read bypass and a per-register busy scoreboard for writeback stalls.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]        ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]        data_writeReg,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] ctrl_readReg,
  output logic [NUM_RD*DATA_WIDTH-1:0] data_readReg,
  output logic [NUM_RD-1:0]            read_busy,
  input  logic                         ctrl_busySet,
  input  logic [ADDR_WIDTH-1:0]        ctrl_busyReg,
  output logic [NUM_REGS-1:0]          busy_vec,
  output logic [DATA_WIDTH-1:0]        r0,
  output logic [DATA_WIDTH-1:0]        r1,
  output logic [DATA_WIDTH-1:0]        r2,
  output logic [DATA_WIDTH-1:0]        r3
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;

  logic wr_en;
  logic set_en;

  assign wr_en  = ctrl_writeEnable && !((ZERO_REG != 0) && (ctrl_writeReg == '0));
  assign set_en = ctrl_busySet && !((ZERO_REG != 0) && (ctrl_busyReg == '0));

  // Busy-set is applied after the write's busy-clear so a same-register set wins.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[ctrl_writeReg] <= data_writeReg;
        busy_q[ctrl_writeReg] <= 1'b0;
      end
      if (set_en) begin
        busy_q[ctrl_busyReg] <= 1'b1;
      end
    end
  end

  always_comb begin
    data_readReg = '0;
    read_busy    = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      logic [ADDR_WIDTH-1:0] addr;
      logic                  zero;
      logic                  byp;
      addr = ctrl_readReg[k*ADDR_WIDTH +: ADDR_WIDTH];
      zero = (ZERO_REG != 0) && (addr == '0);
      // Forwarding is suppressed under reset so outputs read 0 while it is held.
      byp  = (BYPASS != 0) && wr_en && !ctrl_reset && (ctrl_writeReg == addr);
      if (zero) begin
        data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        read_busy[k]                             = 1'b0;
      end else if (byp) begin
        data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = data_writeReg;
        read_busy[k]                             = 1'b0;
      end else begin
        data_readReg[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[addr];
        read_busy[k]                             = busy_q[addr];
      end
    end
  end

  assign busy_vec = busy_q;
  assign r0       = (ZERO_REG != 0) ? '0 : regs_q[0];
  assign r1       = regs_q[1];

  if (NUM_REGS > 2) begin : gen_taps
    assign r2 = regs_q[2];
    assign r3 = regs_q[3];
  end else begin : gen_no_taps
    assign r2 = '0;
    assign r3 = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: behavioural array model with a per-cycle
// compare process, plus directed checks with literal expectations.
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic        ctrl_writeEnable = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic [9:0]  ctrl_readReg = '0;
  logic [63:0] data_readReg;
  logic [1:0]  read_busy;
  logic        ctrl_busySet = 1'b0;
  logic [4:0]  ctrl_busyReg = '0;
  logic [31:0] busy_vec;
  logic [31:0] r0, r1, r2, r3;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_reg [32];
  logic [31:0] m_busy;

  regfile_param dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .read_busy        (read_busy),
    .ctrl_busySet     (ctrl_busySet),
    .ctrl_busyReg     (ctrl_busyReg),
    .busy_vec         (busy_vec),
    .r0               (r0),
    .r1               (r1),
    .r2               (r2),
    .r3               (r3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register 0 never changes, a set on the written register wins.
  always @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_busy = '0;
    end else begin
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_reg[ctrl_writeReg] = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_busySet && ctrl_busyReg != 0) m_busy[ctrl_busyReg] = 1'b1;
    end
  end

  function automatic void model_read(input logic [4:0] a, output logic [31:0] d,
                                     output logic b);
    if (ctrl_reset || a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (ctrl_writeEnable && ctrl_writeReg == a) begin
      d = data_writeReg;
      b = 1'b0;
    end else begin
      d = m_reg[a];
      b = m_busy[a];
    end
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      logic [31:0] d;
      logic        b;
      for (int k = 0; k < 2; k++) begin
        model_read(ctrl_readReg[k*5 +: 5], d, b);
        chk($sformatf("rd_data%0d", k), {32'h0, data_readReg[k*32 +: 32]}, {32'h0, d});
        chk($sformatf("rd_busy%0d", k), {63'h0, read_busy[k]}, {63'h0, b});
      end
      chk("busy_vec", {32'h0, busy_vec}, {32'h0, m_busy});
      chk("r0", {32'h0, r0}, 64'h0);
      chk("r1", {32'h0, r1}, {32'h0, m_reg[1]});
      chk("r2", {32'h0, r2}, {32'h0, m_reg[2]});
      chk("r3", {32'h0, r3}, {32'h0, m_reg[3]});
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic bs, input logic [4:0] ba);
    ctrl_writeEnable = we;
    ctrl_writeReg    = wa;
    data_writeReg    = wd;
    ctrl_readReg     = {ra1, ra0};
    ctrl_busySet     = bs;
    ctrl_busyReg     = ba;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #1 ctrl_reset = 1'b1;
    #1 chk_en = 1'b1;
    next_cycle();
    next_cycle();
    ctrl_reset = 1'b0;

    // Reset contents: every address reads 0 on both ports.
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(a), 1'b0, 5'd0);
      #2;
      chk("reset_rd0", {32'h0, data_readReg[31:0]}, 64'h0);
      chk("reset_rd1", {32'h0, data_readReg[63:32]}, 64'h0);
      chk("reset_busy", {32'h0, busy_vec}, 64'h0);
      next_cycle();
    end

    // Bypass on port1 in the write cycle, stored value on port0 afterwards.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, 1'b0, 5'd0);
    #2 chk("bypass_p1", {32'h0, data_readReg[63:32]}, 64'hDEADBEEF);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    #2 chk("stored_p0", {32'h0, data_readReg[31:0]}, 64'hDEADBEEF);
    next_cycle();

    // Writes to register 0 are dropped, including the bypass path.
    drive(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 5'd0);
    #2 chk("zero_bypass", {32'h0, data_readReg[31:0]}, 64'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    #2 chk("zero_rd", {32'h0, data_readReg[31:0]}, 64'h0);
    chk("zero_r0", {32'h0, r0}, 64'h0);
    next_cycle();

    // Busy set then cleared by writeback.
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
    #2 chk("busy7_vec", {63'h0, busy_vec[7]}, 64'h1);
    chk("busy7_rd", {63'h0, read_busy[0]}, 64'h1);
    next_cycle();
    drive(1'b1, 5'd7, 32'hA5, 5'd7, 5'd0, 1'b0, 5'd0);
    #2 chk("busy7_byp", {63'h0, read_busy[0]}, 64'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
    #2 chk("busy7_clr", {63'h0, busy_vec[7]}, 64'h0);
    chk("data7", {32'h0, data_readReg[31:0]}, 64'hA5);
    next_cycle();

    // Same-cycle set and write: set wins, data still lands.
    drive(1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b1, 5'd9);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
    #2 chk("busy9_vec", {63'h0, busy_vec[9]}, 64'h1);
    chk("data9", {32'h0, data_readReg[31:0]}, 64'h55);
    chk("busy9_rd", {63'h0, read_busy[1]}, 64'h1);
    next_cycle();

    // Asynchronous reset between edges.
    drive(1'b1, 5'd3, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd12);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    #1 chk("r3_full", {32'h0, r3}, 64'hFFFFFFFF);
    chk("busy12", {63'h0, busy_vec[12]}, 64'h1);
    ctrl_reset = 1'b1;
    #1 chk("r3_async", {32'h0, r3}, 64'h0);
    chk("busy_async", {32'h0, busy_vec}, 64'h0);
    chk("rd_async", {32'h0, data_readReg[31:0]}, 64'h0);
    ctrl_reset = 1'b0;
    drive(1'b1, 5'd3, 32'h1, 5'd3, 5'd0, 1'b0, 5'd0);
    #1 chk("r3_pre_edge", {32'h0, r3}, 64'h0);
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0);
    #1 chk("r3_post_edge", {32'h0, r3}, 64'h1);
    next_cycle();

    // Randomised traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 3000; n++) begin
      drive(1'($urandom_range(0, 1)), rand_addr(), $urandom(), rand_addr(), rand_addr(),
            1'($urandom_range(0, 2) == 0), rand_addr());
      if ($urandom_range(0, 199) == 0) begin
        #1 ctrl_reset = 1'b1;
        #1 ctrl_reset = 1'b0;
      end
      next_cycle();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised multi-port register file: the next-generation replacement for the fixed 32x32, 2-read-port register file in the processor datapath.
- Adds the following:
  - configurable width, depth and read-port count
  - optional hardwired-zero register 0
  - write-to-read bypass
  - per-register busy scoreboard, so the pipeline control can stall on pending writebacks
- Sits between decode (read and busy-set) and writeback (write and busy-clear).

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, number of registers (power of 2, >=2)
ADDR_WIDTH, 5, log2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and busy-set
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data

Ports:
clock  in  1  system clock; all state updates on the rising edge
ctrl_reset  in  1  asynchronous, active-high reset
ctrl_writeEnable  in  1  write strobe
ctrl_writeReg  in  ADDR_WIDTH  write address
data_writeReg  in  DATA_WIDTH  write data
ctrl_readReg  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH]
data_readReg  out  NUM_RD*DATA_WIDTH  packed read data, same slicing
read_busy  out  NUM_RD  busy bit of each addressed register
ctrl_busySet  in  1  mark ctrl_busyReg as pending
ctrl_busyReg  in  ADDR_WIDTH  register to mark pending
busy_vec  out  NUM_REGS  full scoreboard
r0, r1, r2, r3  out  DATA_WIDTH each  debug taps of registers 0-3 (raw storage, no bypass)

Behaviour:
- Reset (asynchronous, ctrl_reset=1):
  - all registers become 0; busy_vec becomes 0
  - consequently data_readReg, r0-r3, read_busy and busy_vec are all 0 while reset is held
  - reset wins over any same-cycle write or busy-set
- Write:
  - on the rising clock edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg
  - same edge: busy[ctrl_writeReg] <= 0, unless the busy-set rule below overrides
- Busy-set:
  - on the rising edge with ctrl_busySet=1, busy[ctrl_busyReg] <= 1
  - if set and write target the same register in the same cycle, the set wins: busy ends at 1 and the data is still written
  - set of an already-busy register leaves it at 1
- Zero register (ZERO_REG=1):
  - writes to address 0 are dropped; busy-set of address 0 is dropped
  - reads of address 0 return 0 with read_busy=0, including under bypass
  - r0 reads 0
  - with ZERO_REG=0, register 0 behaves like every other register
- Read:
  - combinational, zero latency, independent per port
  - all ports may address the same register
- Bypass:
  - with BYPASS=1, ctrl_writeEnable=1 and ctrl_writeReg equal to the port's address (and not zero-suppressed), the port returns data_writeReg in the same cycle; that port's read_busy also reads 0
  - with BYPASS=0, the read returns the stored value until after the edge
- read_busy[k] = busy[addr_k], subject to the bypass and zero-register overrides above.
- Out-of-range addresses cannot occur, because NUM_REGS = 2^ADDR_WIDTH.
- Reset asserted mid-operation (between edges) clears state immediately; the first write after deassertion takes effect on the next rising edge.
- There is no other internal state; the sequential elements are NUM_REGS*DATA_WIDTH data flops plus NUM_REGS busy flops.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every data_readReg = 0; busy_vec = 0.
2. Write reg5 = 0xDEADBEEF, next cycle read port0 = 5 -> 0xDEADBEEF. The same cycle as the write, port1 = 5:
   - BYPASS=1 -> 0xDEADBEEF
   - BYPASS=0 -> 0
3. Write reg0 = 0x12345678 with ZERO_REG=1 -> port0 at addr 0 reads 0 and r0 = 0. With ZERO_REG=0 -> 0x12345678.
4. busySet reg7 -> busy_vec[7] = 1 and read_busy = 1 at addr 7. Later write reg7 = 0xA5 -> busy_vec[7] = 0 after the edge, and data reads 0xA5.
5. Same cycle: busySet reg9 and write reg9 = 0x55 -> busy_vec[9] = 1 and reg9 = 0x55.
6. Write reg3 = 0xFFFFFFFF, then assert ctrl_reset between clock edges -> r3 and busy_vec go to 0 immediately without a clock edge. After deassertion, a write of 0x1 to reg3 is visible after the next edge.
